// File: rtl/regbank_v2.sv
// regbank_v2: parametrised CPU register bank.
//   - 2^AW registers of DATA_W bits, register 0 reads as zero and is never pending
//   - two combinational read ports, one write port with per-lane write enables
//   - pending-write scoreboard (issue sets, writeback clears, set wins on collision)
//   - clear sequencer that sweeps zeros through the array after reset or on clr_req_i
// Optional feature macro: REGBANK_V2_BYPASS_EN enables same-cycle write-to-read
// forwarding (per-lane merge) on both read ports.
module regbank_v2 #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 16,
  parameter int AW     = 4,
  localparam int LANES = DATA_W / LANE_W
) (
  input  logic              clk_i,
  input  logic              reset_ni,     // asynchronous, active-low
  input  logic              clr_req_i,
  output logic              busy_o,
  input  logic [AW-1:0]     addr_a_i,
  input  logic [AW-1:0]     addr_b_i,
  output logic [DATA_W-1:0] data_a_o,
  output logic [DATA_W-1:0] data_b_o,
  output logic              hz_a_o,
  output logic              hz_b_o,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_addr_i,
  input  logic [AW-1:0]     addr_d_i,
  input  logic [DATA_W-1:0] data_d_i,
  input  logic              we_i,
  input  logic [LANES-1:0]  lane_we_i
);

  localparam int NREGS = 1 << AW;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t               state_q;
  logic [AW-1:0]        ptr_q;
  logic [NREGS-1:0]     pending_q;
  logic [NREGS-1:0]     pending_d;
  logic [DATA_W-1:0]    mem_q [NREGS];
  logic [DATA_W-1:0]    wr_data_d;
  logic                 wr_act;

  // Replace only the lanes whose mask bit is set; data_d is already lane-aligned.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] stored,
    input logic [DATA_W-1:0] wdata,
    input logic [LANES-1:0]  mask
  );
    logic [DATA_W-1:0] res;
    res = stored;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) res[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
    end
    return res;
  endfunction

  assign busy_o    = (state_q == SWEEP);
  // A write is architecturally visible only when idle and not aimed at r0.
  assign wr_act    = (state_q == IDLE) && we_i && (addr_d_i != '0);
  assign wr_data_d = merge_lanes(mem_q[addr_d_i], data_d_i, lane_we_i);

  // Scoreboard next state: writeback clears, issue sets afterwards so set wins.
  always_comb begin
    pending_d = pending_q;
    if (we_i && (addr_d_i != '0))
      pending_d[addr_d_i] = 1'b0;
    if (iss_valid_i && (iss_addr_i != '0))
      pending_d[iss_addr_i] = 1'b1;
  end

  // Control FSM: clear sweep pointer, state and scoreboard.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= SWEEP;
      ptr_q     <= '0;
      pending_q <= '0;
    end else begin
      case (state_q)
        SWEEP: begin
          pending_q <= '0;
          ptr_q     <= ptr_q + AW'(1);
          if (ptr_q == AW'(NREGS - 1))
            state_q <= IDLE;
        end
        IDLE: begin
          if (clr_req_i) begin
            state_q   <= SWEEP;
            ptr_q     <= '0;
            pending_q <= '0;
          end else begin
            pending_q <= pending_d;
          end
        end
        default: begin
          state_q <= SWEEP;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  // Storage array: no reset, initialised only by the sweep; external writes when idle.
  always_ff @(posedge clk_i) begin
    if (state_q == SWEEP)
      mem_q[ptr_q] <= '0;
    else if (wr_act)
      mem_q[addr_d_i] <= wr_data_d;
  end

  // Read port A: zero while sweeping, r0 always zero, optional forwarding.
  always_comb begin
    data_a_o = '0;
    hz_a_o   = 1'b0;
    if (!busy_o) begin
      data_a_o = (addr_a_i == '0) ? '0 : mem_q[addr_a_i];
      hz_a_o   = pending_q[addr_a_i];
`ifdef REGBANK_V2_BYPASS_EN
      if (wr_act && (addr_a_i == addr_d_i)) begin
        data_a_o = wr_data_d;
        hz_a_o   = 1'b0;
      end
`endif
    end
  end

  // Read port B: identical behaviour to port A.
  always_comb begin
    data_b_o = '0;
    hz_b_o   = 1'b0;
    if (!busy_o) begin
      data_b_o = (addr_b_i == '0) ? '0 : mem_q[addr_b_i];
      hz_b_o   = pending_q[addr_b_i];
`ifdef REGBANK_V2_BYPASS_EN
      if (wr_act && (addr_b_i == addr_d_i)) begin
        data_b_o = wr_data_d;
        hz_b_o   = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regbank_v2.sv
// Directed self-checking bench for regbank_v2 (default parameters, NREGS = 16).
module tb_regbank_v2;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        clr_req;
  logic        busy;
  logic [3:0]  addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic        hz_a, hz_b;
  logic        iss_valid;
  logic [3:0]  iss_addr;
  logic [3:0]  addr_d;
  logic [31:0] data_d;
  logic        we;
  logic [1:0]  lane_we;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  regbank_v2 dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .clr_req_i   (clr_req),
    .busy_o      (busy),
    .addr_a_i    (addr_a),
    .addr_b_i    (addr_b),
    .data_a_o    (data_a),
    .data_b_o    (data_b),
    .hz_a_o      (hz_a),
    .hz_b_o      (hz_b),
    .iss_valid_i (iss_valid),
    .iss_addr_i  (iss_addr),
    .addr_d_i    (addr_d),
    .data_d_i    (data_d),
    .we_i        (we),
    .lane_we_i   (lane_we)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_ni = 1'b0; clr_req = 1'b0; addr_a = '0; addr_b = '0;
    iss_valid = 1'b0; iss_addr = '0; addr_d = '0; data_d = '0; we = 1'b0; lane_we = '0;
    step();
    step();
    addr_a = 4'd3; addr_b = 4'd9;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_data_a", data_a, 32'h0);
    check("rst_data_b", data_b, 32'h0);
    check("rst_hz", {30'b0, hz_a, hz_b}, 32'd0);

    // Release reset: busy for exactly 16 edges
    reset_ni = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("init_busy_%0d", i), {31'b0, busy}, 32'd1);
      step();
    end
    check("init_busy_fall", {31'b0, busy}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      addr_a = 4'(a); addr_b = 4'(15 - a);
      #1;
      check($sformatf("init_rd_%0d", a), data_a | data_b, 32'h0);
      check($sformatf("init_hz_%0d", a), {30'b0, hz_a, hz_b}, 32'd0);
    end

    // Full write then upper-lane-only write to r5
    we = 1'b1; addr_d = 4'd5; data_d = 32'hDEADBEEF; lane_we = 2'b11;
    step();
    data_d = 32'h1234_0000; lane_we = 2'b10;
    step();
    we = 1'b0; addr_a = 4'd5; addr_b = 4'd5;
    #1;
    check("lane_merge_a", data_a, 32'h1234BEEF);
    check("lane_merge_b", data_b, 32'h1234BEEF);

    // r0 ignores writes and never becomes pending
    we = 1'b1; addr_d = 4'd0; data_d = 32'hFFFFFFFF; lane_we = 2'b11;
    iss_valid = 1'b1; iss_addr = 4'd0;
    step();
    we = 1'b0; iss_valid = 1'b0; addr_a = 4'd0; addr_b = 4'd0;
    #1;
    check("r0_data", data_a, 32'h0);
    check("r0_hz", {31'b0, hz_b}, 32'd0);

    // Scoreboard on r7
    iss_valid = 1'b1; iss_addr = 4'd7;
    step();
    iss_valid = 1'b0; addr_a = 4'd7; addr_b = 4'd7;
    #1;
    check("iss_hz_a", {31'b0, hz_a}, 32'd1);
    check("iss_hz_b", {31'b0, hz_b}, 32'd1);
    we = 1'b1; addr_d = 4'd7; data_d = 32'h5555AAAA; lane_we = 2'b11;
    iss_valid = 1'b1; iss_addr = 4'd7;
    step();
    we = 1'b0; iss_valid = 1'b0;
    #1;
    check("set_wins_hz", {31'b0, hz_a}, 32'd1);
    we = 1'b1; addr_d = 4'd7; data_d = 32'hA5A5A5A5; lane_we = 2'b11;
    #1;
`ifdef REGBANK_V2_BYPASS_EN
    check("wr_cycle_hz", {31'b0, hz_a}, 32'd0);
`else
    check("wr_cycle_hz", {31'b0, hz_a}, 32'd1);
`endif
    step();
    we = 1'b0;
    #1;
    check("wr_clr_hz", {31'b0, hz_a}, 32'd0);
    check("wr_r7_data", data_a, 32'hA5A5A5A5);

    // Empty lane mask still clears pending and changes nothing
    iss_valid = 1'b1; iss_addr = 4'd9;
    step();
    iss_valid = 1'b0; addr_a = 4'd9;
    #1;
    check("iss9_hz", {31'b0, hz_a}, 32'd1);
    we = 1'b1; addr_d = 4'd9; data_d = 32'hFFFFFFFF; lane_we = 2'b00;
    step();
    we = 1'b0;
    #1;
    check("nolane_hz", {31'b0, hz_a}, 32'd0);
    check("nolane_data", data_a, 32'h0);

    // Forwarding on r3
    we = 1'b1; addr_d = 4'd3; data_d = 32'h11112222; lane_we = 2'b11;
    step();
    data_d = 32'hCAFEF00D; lane_we = 2'b01; addr_a = 4'd3; addr_b = 4'd3;
    #1;
`ifdef REGBANK_V2_BYPASS_EN
    check("bypass_a", data_a, 32'h1111F00D);
    check("bypass_b", data_b, 32'h1111F00D);
`else
    check("bypass_a", data_a, 32'h11112222);
    check("bypass_b", data_b, 32'h11112222);
`endif
    step();
    we = 1'b0;
    #1;
    check("post_bypass", data_a, 32'h1111F00D);

    // Load r1..r15, mark r4 pending, then clear sweep
    for (int r = 1; r < 16; r++) begin
      we = 1'b1; addr_d = 4'(r); data_d = 32'h100 + 32'(r); lane_we = 2'b11;
      step();
    end
    we = 1'b0;
    iss_valid = 1'b1; iss_addr = 4'd4;
    step();
    iss_valid = 1'b0; addr_a = 4'd12; addr_b = 4'd4;
    #1;
    check("load_r12", data_a, 32'h10C);
    check("load_hz4", {31'b0, hz_b}, 32'd1);
    clr_req = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      clr_req = (k == 5);
      #1;
      check($sformatf("clr_busy_%0d", k), {31'b0, busy}, 32'd1);
      if (k == 2) check("clr_rd_busy", data_a, 32'h0);
      step();
    end
    clr_req = 1'b0;
    check("clr_busy_fall", {31'b0, busy}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      addr_a = 4'(a); addr_b = 4'(a);
      #1;
      check($sformatf("clr_rd_%0d", a), data_a | data_b, 32'h0);
      check($sformatf("clr_hz_%0d", a), {30'b0, hz_a, hz_b}, 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
